// File: rtl/projection_scheduler.sv
// Projection scheduler: walks a triangle list in mesh memory, sends one triangle at a
// time through the projection unit, and forwards accepted results to the rasterizer.
// Each frame keeps separate tallies of drawn, clipped and errored triangles.
module projection_scheduler #(
    parameter int unsigned COORD_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH  = 10,
    parameter int unsigned MEM_LATENCY = 2
) (
    input  logic                        clk_in,
    input  logic                        rst_in_n,
    input  logic                        frame_start,
    input  logic [ADDR_WIDTH-1:0]       num_tris,
    output logic [ADDR_WIDTH-1:0]       mem_addr,
    input  logic [9*COORD_WIDTH-1:0]    mem_data,
    output logic                        proj_start,
    output logic [9*COORD_WIDTH-1:0]    proj_verts,
    input  logic                        proj_done,
    input  logic                        proj_valid,
    input  logic [1:0]                  proj_status,
    input  logic [9*COORD_WIDTH-1:0]    proj_result,
    output logic [9*COORD_WIDTH-1:0]    out_tri,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic                        frame_busy,
    output logic                        frame_done,
    output logic [ADDR_WIDTH:0]         drawn_count,
    output logic [ADDR_WIDTH:0]         clip_count,
    output logic [ADDR_WIDTH:0]         err_count
);

    localparam int unsigned TriW = 9 * COORD_WIDTH;
    localparam int unsigned CntW = ADDR_WIDTH + 1;
    localparam int unsigned LatW = $clog2(MEM_LATENCY + 1);

    localparam logic [LatW-1:0]       LatLast = LatW'(MEM_LATENCY);
    localparam logic [LatW-1:0]       LatOne  = LatW'(1);
    localparam logic [ADDR_WIDTH-1:0] AddrOne = ADDR_WIDTH'(1);
    localparam logic [CntW-1:0]       CntOne  = CntW'(1);

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StLaunch,
        StWait,
        StEmit,
        StNext,
        StDone
    } state_e;

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] total_q, total_d;
    logic [ADDR_WIDTH-1:0] index_q, index_d;
    logic [LatW-1:0]       lat_q, lat_d;
    logic [TriW-1:0]       verts_q, verts_d;
    logic [TriW-1:0]       tri_q, tri_d;
    logic                  valid_q, valid_d;
    logic                  busy_q, busy_d;
    logic [CntW-1:0]       drawn_q, drawn_d;
    logic [CntW-1:0]       clip_q, clip_d;
    logic [CntW-1:0]       err_q, err_d;

    // Next-state and datapath updates; every register holds unless its state acts on it.
    always_comb begin
        state_d = state_q;
        total_d = total_q;
        index_d = index_q;
        lat_d   = lat_q;
        verts_d = verts_q;
        tri_d   = tri_q;
        valid_d = valid_q;
        busy_d  = busy_q;
        drawn_d = drawn_q;
        clip_d  = clip_q;
        err_d   = err_q;

        case (state_q)
            StIdle: begin
                if (frame_start) begin
                    total_d = num_tris;
                    index_d = '0;
                    lat_d   = '0;
                    drawn_d = '0;
                    clip_d  = '0;
                    err_d   = '0;
                    busy_d  = 1'b1;
                    state_d = (num_tris == '0) ? StDone : StFetch;
                end
            end
            StFetch: begin
                // Address is held for MEM_LATENCY cycles; the read data lands on the next one.
                if (lat_q == LatLast) begin
                    verts_d = mem_data;
                    state_d = StLaunch;
                end else begin
                    lat_d = lat_q + LatOne;
                end
            end
            StLaunch: begin
                state_d = StWait;
            end
            StWait: begin
                if (proj_done) begin
                    if (proj_valid) begin
                        tri_d   = proj_result;
                        valid_d = 1'b1;
                        state_d = StEmit;
                    end else begin
                        if (proj_status == 2'b01) begin
                            clip_d = clip_q + CntOne;
                        end else begin
                            err_d = err_q + CntOne;
                        end
                        state_d = StNext;
                    end
                end
            end
            StEmit: begin
                if (out_ready) begin
                    valid_d = 1'b0;
                    drawn_d = drawn_q + CntOne;
                    state_d = StNext;
                end
            end
            StNext: begin
                if (index_q == total_q - AddrOne) begin
                    state_d = StDone;
                end else begin
                    index_d = index_q + AddrOne;
                    lat_d   = '0;
                    state_d = StFetch;
                end
            end
            StDone: begin
                busy_d  = 1'b0;
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State and datapath registers; reset clears every visible output immediately.
    always_ff @(posedge clk_in or negedge rst_in_n) begin
        if (!rst_in_n) begin
            state_q <= StIdle;
            total_q <= '0;
            index_q <= '0;
            lat_q   <= '0;
            verts_q <= '0;
            tri_q   <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            drawn_q <= '0;
            clip_q  <= '0;
            err_q   <= '0;
        end else begin
            state_q <= state_d;
            total_q <= total_d;
            index_q <= index_d;
            lat_q   <= lat_d;
            verts_q <= verts_d;
            tri_q   <= tri_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            drawn_q <= drawn_d;
            clip_q  <= clip_d;
            err_q   <= err_d;
        end
    end

    // The read address always tracks the triangle index.
    assign mem_addr    = index_q;
    assign proj_start  = (state_q == StLaunch);
    assign frame_done  = (state_q == StDone);
    assign proj_verts  = verts_q;
    assign out_tri     = tri_q;
    assign out_valid   = valid_q;
    assign frame_busy  = busy_q;
    assign drawn_count = drawn_q;
    assign clip_count  = clip_q;
    assign err_count   = err_q;

endmodule

// File: tb/tb_projection_scheduler.sv
// Randomized bench for projection_scheduler: BRAM model, projection-unit model,
// rasterizer back-pressure and a per-frame reference of launches, beats and tallies.
module tb_projection_scheduler;

    localparam int unsigned CW   = 32;
    localparam int unsigned AW   = 6;
    localparam int unsigned ML   = 2;
    localparam int unsigned VW   = 9 * CW;
    localparam int unsigned CNTW = AW + 1;
    localparam int unsigned NMEM = 1 << AW;

    typedef logic [VW-1:0] vec_t;

    logic            clk_in = 1'b0;
    logic            rst_in_n;
    logic            frame_start;
    logic [AW-1:0]   num_tris;
    logic [AW-1:0]   mem_addr;
    vec_t            mem_data;
    logic            proj_start;
    vec_t            proj_verts;
    logic            proj_done;
    logic            proj_valid;
    logic [1:0]      proj_status;
    vec_t            proj_result;
    vec_t            out_tri;
    logic            out_valid;
    logic            out_ready;
    logic            frame_busy;
    logic            frame_done;
    logic [CNTW-1:0] drawn_count;
    logic [CNTW-1:0] clip_count;
    logic [CNTW-1:0] err_count;

    projection_scheduler #(
        .COORD_WIDTH(CW),
        .ADDR_WIDTH (AW),
        .MEM_LATENCY(ML)
    ) dut (
        .clk_in     (clk_in),
        .rst_in_n   (rst_in_n),
        .frame_start(frame_start),
        .num_tris   (num_tris),
        .mem_addr   (mem_addr),
        .mem_data   (mem_data),
        .proj_start (proj_start),
        .proj_verts (proj_verts),
        .proj_done  (proj_done),
        .proj_valid (proj_valid),
        .proj_status(proj_status),
        .proj_result(proj_result),
        .out_tri    (out_tri),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .frame_busy (frame_busy),
        .frame_done (frame_done),
        .drawn_count(drawn_count),
        .clip_count (clip_count),
        .err_count  (err_count)
    );

    initial forever #5 clk_in = ~clk_in;

    // Mesh BRAM: data appears ML cycles after the address.
    vec_t mem [NMEM];
    vec_t mem_pipe [ML];
    always @(posedge clk_in) begin
        mem_pipe[0] <= mem[mem_addr];
        for (int i = 1; i < ML; i++) mem_pipe[i] <= mem_pipe[i-1];
    end
    assign mem_data = mem_pipe[ML-1];

    int   n_checks = 0;
    int   n_pass   = 0;
    int   frame_n, launch_idx, exp_drawn, exp_clip, exp_err;
    int   plan [NMEM];
    vec_t beats [$];
    bit   frame_active = 0;
    bit   done_seen, pend, prev_stall, noise, start_pending;
    int   delay, cur_idx, stall_cnt, ready_mode, start_n;
    vec_t prev_tri;

    task automatic check(input string tag, input vec_t got, input vec_t exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    function automatic vec_t rand_vec();
        vec_t v;
        for (int k = 0; k < 9; k++) v[k*CW +: CW] = $urandom;
        return v;
    endfunction

    // Stand-in projection transform applied by the projection-unit model.
    function automatic vec_t xform(input vec_t v);
        return ~v ^ {9{32'h1357_9BDF}};
    endfunction

    task automatic check_all_zero(input string tag);
        check({tag, "_mem_addr"}, vec_t'(mem_addr), '0);
        check({tag, "_proj_start"}, vec_t'(proj_start), '0);
        check({tag, "_proj_verts"}, proj_verts, '0);
        check({tag, "_out_tri"}, out_tri, '0);
        check({tag, "_out_valid"}, vec_t'(out_valid), '0);
        check({tag, "_frame_busy"}, vec_t'(frame_busy), '0);
        check({tag, "_frame_done"}, vec_t'(frame_done), '0);
        check({tag, "_drawn"}, vec_t'(drawn_count), '0);
        check({tag, "_clip"}, vec_t'(clip_count), '0);
        check({tag, "_err"}, vec_t'(err_count), '0);
    endtask

    // One cycle of the environment: observe at the falling edge, then drive inputs.
    task automatic tick();
        @(negedge clk_in);
        if (proj_start) begin
            check("launch_in_range", vec_t'(launch_idx < frame_n), vec_t'(1));
            check("launch_addr", vec_t'(mem_addr), vec_t'(launch_idx));
            check("launch_verts", proj_verts, mem[launch_idx % NMEM]);
            check("one_in_flight", vec_t'(out_valid), '0);
            pend = 1;
            delay = $urandom_range(2, 6);
            cur_idx = launch_idx % NMEM;
            launch_idx++;
        end
        if (prev_stall) begin
            check("hold_valid", vec_t'(out_valid), vec_t'(1));
            check("hold_tri", out_tri, prev_tri);
        end
        if (!frame_active) begin
            check("no_stray_done", vec_t'(frame_done), '0);
        end else if (frame_done) begin
            check("busy_at_done", vec_t'(frame_busy), vec_t'(1));
            check("drawn", vec_t'(drawn_count), vec_t'(exp_drawn));
            check("clip", vec_t'(clip_count), vec_t'(exp_clip));
            check("err", vec_t'(err_count), vec_t'(exp_err));
            check("tally_sum", vec_t'(drawn_count) + vec_t'(clip_count) + vec_t'(err_count),
                  vec_t'(frame_n));
            check("launch_total", vec_t'(launch_idx), vec_t'(frame_n));
            check("beats_left", vec_t'(beats.size()), '0);
            frame_active = 0;
            done_seen = 1;
        end

        case (ready_mode)
            0: out_ready = 1'b1;
            1: out_ready = 1'($urandom_range(0, 1));
            default: begin
                if (out_valid) begin
                    if (stall_cnt < 7) begin
                        out_ready = 1'b0;
                        stall_cnt++;
                    end else begin
                        out_ready = 1'b1;
                    end
                end else begin
                    out_ready = 1'b0;
                    stall_cnt = 0;
                end
            end
        endcase
        if (out_valid && out_ready) begin
            check("beat_available", vec_t'(beats.size() > 0), vec_t'(1));
            if (beats.size() > 0) check("beat_tri", out_tri, beats.pop_front());
            if (ready_mode == 2) check("stall_len", vec_t'(stall_cnt), vec_t'(7));
        end
        prev_stall = out_valid && !out_ready;
        prev_tri = out_tri;

        proj_done = 1'b0;
        proj_valid = 1'b0;
        proj_status = 2'b00;
        proj_result = rand_vec();
        if (pend) begin
            delay--;
            if (delay == 0) begin
                pend = 0;
                proj_done = 1'b1;
                case (plan[cur_idx])
                    0: begin
                        proj_valid = 1'b1;
                        proj_result = xform(mem[cur_idx]);
                    end
                    1: proj_status = 2'b01;
                    2: proj_status = 2'b10;
                    default: proj_status = ($urandom_range(0, 1) == 1) ? 2'b11 : 2'b00;
                endcase
            end
        end else if (noise && $urandom_range(0, 3) == 0) begin
            proj_done = 1'b1;
            proj_valid = 1'($urandom_range(0, 1));
            proj_status = 2'($urandom);
        end

        if (start_pending) begin
            frame_start = 1'b1;
            num_tris = AW'(start_n);
            start_pending = 0;
        end else if (noise && frame_busy && $urandom_range(0, 5) == 0) begin
            frame_start = 1'b1;
            num_tris = AW'($urandom);
        end else begin
            frame_start = 1'b0;
            if (noise) num_tris = AW'($urandom);
        end
    endtask

    // Reference for one frame: launches in index order, beats only for passing triangles.
    task automatic setup_frame(input int n, input int pmode, input int rmode, input bit nz);
        frame_n = n;
        beats.delete();
        exp_drawn = 0;
        exp_clip = 0;
        exp_err = 0;
        for (int i = 0; i < n; i++) begin
            case (pmode)
                0: plan[i] = 0;
                1: plan[i] = $urandom_range(0, 3);
                default: plan[i] = (i == 1) ? 1 : (i == 3) ? 2 : 0;
            endcase
            if (plan[i] == 0) begin
                beats.push_back(xform(mem[i]));
                exp_drawn++;
            end else if (plan[i] == 1) begin
                exp_clip++;
            end else begin
                exp_err++;
            end
        end
        launch_idx = 0;
        done_seen = 0;
        frame_active = 1;
        pend = 0;
        prev_stall = 0;
        stall_cnt = 0;
        start_pending = 1;
        start_n = n;
        ready_mode = rmode;
        noise = nz;
    endtask

    task automatic run_frame(input int n, input int pmode, input int rmode, input bit nz);
        int cycles;
        setup_frame(n, pmode, rmode, nz);
        tick();
        tick();
        cycles = 1;
        check("busy_after_start", vec_t'(frame_busy), vec_t'(1));
        while (!done_seen && cycles < 5000) begin
            tick();
            cycles++;
        end
        check("frame_done_seen", vec_t'(done_seen), vec_t'(1));
        if (n == 0) check("zero_done_latency", vec_t'(cycles), vec_t'(1));
        frame_active = 0;
        tick();
        check("busy_cleared", vec_t'(frame_busy), '0);
        check("counts_hold", vec_t'(drawn_count), vec_t'(exp_drawn));
    endtask

    initial begin
        int cycles;
        for (int i = 0; i < NMEM; i++) mem[i] = rand_vec();
        rst_in_n = 1'b0;
        frame_start = 1'b0;
        num_tris = '0;
        proj_done = 1'b0;
        proj_valid = 1'b0;
        proj_status = 2'b00;
        proj_result = '0;
        out_ready = 1'b0;
        ready_mode = 0;
        noise = 0;
        start_pending = 0;
        repeat (3) @(negedge clk_in);
        check_all_zero("reset");
        @(posedge clk_in);
        #2 rst_in_n = 1'b1;

        run_frame(0, 0, 0, 0);
        run_frame(3, 0, 0, 0);
        run_frame(4, 2, 0, 0);
        run_frame(3, 0, 2, 0);
        run_frame(5, 1, 1, 1);
        for (int f = 0; f < 5; f++) begin
            run_frame($urandom_range(1, 12), 1, $urandom_range(0, 2), 1'($urandom_range(0, 1)));
        end
        run_frame(NMEM - 1, 1, 0, 0);

        // Abandon a frame while the projection unit is busy.
        setup_frame(5, 0, 0, 0);
        tick();
        cycles = 0;
        while (!pend && cycles < 200) begin
            tick();
            cycles++;
        end
        check("reached_wait", vec_t'(pend), vec_t'(1));
        @(posedge clk_in);
        #3 rst_in_n = 1'b0;
        #1 check_all_zero("async");
        frame_active = 0;
        pend = 0;
        prev_stall = 0;
        beats.delete();
        repeat (3) tick();
        check_all_zero("held");
        @(posedge clk_in);
        #4 rst_in_n = 1'b1;
        run_frame(1, 0, 0, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
